serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter: WIDTH, default 8, frame shift-register width; legal range 2..15.
REQ-002 Port: Clock  input  1  sole clock; all state updates on posedge Clock.
REQ-003 Port: Reset  input  1  synchronous, active-high reset, sampled on posedge Clock.
REQ-004 Port: start  input  1  frame request; sampled only in IDLE.
REQ-005 Port: data  input  WIDTH  frame bits, captured on accepted start; transmitted MSB first.
REQ-006 Port: len  input  4  number of bits to send; 0 and values >WIDTH mean WIDTH.
REQ-007 Port: w  output  1  serial bit stream toward the two-consecutive-ones detector (its w input).
REQ-008 Port: w_valid  output  1  high exactly in cycles where w carries a frame bit.
REQ-009 Port: busy  output  1  high in SHIFT and DONE.
REQ-010 Port: done  output  1  one-cycle pulse at frame completion.
REQ-011 Port: hit_count  output  4  predicted number of cycles in which the receiving detector's z is 1 for this frame; held from done until the next accepted start.

Function
REQ-012 Control SHALL be a Moore FSM with states IDLE, SHIFT, DONE; outputs w, w_valid, busy, done SHALL depend only on state and registers, with no combinational path from any input.
REQ-013 IDLE: w=0, w_valid=0, busy=0, done=0; start=1 SHALL capture data into the shift register, load the bit counter with the effective len, clear hit_count and the previous-bit register, and move to SHIFT.
REQ-014 SHIFT: w = shift-register MSB, w_valid=1, busy=1; each cycle the register SHALL shift left with 0 fill and the counter SHALL decrement.
REQ-015 SHIFT SHALL last exactly effective-len cycles, then move to DONE.
REQ-016 DONE: w=0, w_valid=0, busy=1, done=1 for one cycle, then IDLE unconditionally.
REQ-017 Latency: start accepted at edge t -> first bit on w in cycle t+1; done high in cycle t+len+1; next start sampled in IDLE at t+len+2 at the earliest.
REQ-018 start during SHIFT or DONE SHALL be ignored; it is not queued.
REQ-019 During SHIFT, hit_count SHALL increment when the current w and the previous frame bit are both 1 (runs counted within a frame only; the first bit never counts).
REQ-020 hit_count SHALL not wrap (maximum WIDTH-1 <= 14 fits 4 bits).
REQ-021 Unused state encodings SHALL transition to IDLE on the next edge with IDLE outputs.
REQ-022 data and len changes after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-023 Reset=1 at a posedge SHALL force IDLE, w=0, w_valid=0, busy=0, done=0, hit_count=0, shift register and counter cleared.
REQ-024 Reset SHALL take priority over start and over any in-progress SHIFT/DONE; an aborted frame SHALL produce no done pulse.
REQ-025 Reset asserted between edges SHALL have no effect until the next posedge Clock.

Verification
REQ-026 Reset for 2 cycles with start=1 -> all outputs 0, FSM in IDLE, no frame started.
REQ-027 data=8'b1011_0111, len=8, start pulse at t -> w=1,0,1,1,0,1,1,1 in cycles t+1..t+8 with w_valid=1; done at t+9; hit_count=3.
REQ-028 data=8'hE0, len=3 -> w=1,1,1 in t+1..t+3; done at t+4; hit_count=2; w_valid low from t+4.
REQ-029 data=8'hFF, len=0 (and separately len=12) -> 8 ones; done at t+9; hit_count=7.
REQ-030 Reset=1 at the 4th SHIFT cycle of a len=8 frame -> IDLE next cycle, busy=0, hit_count=0, no done pulse.
REQ-031 start held high continuously, len=2, data=8'hC0 -> frames repeat with pattern w_valid 1,1,0,0 (DONE, IDLE), each frame hit_count=1, done once per frame.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first frame serializer that predicts two-consecutive-ones detector hits
module serial_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       len,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       hit_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [3:0] cnt, eff_len;
  logic prev, last;
  always_comb eff_len = (len == 4'd0 || len > 4'(WIDTH)) ? 4'(WIDTH) : len;
  always_comb last = cnt == 4'd1;
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      prev <= 1'b0;
      w <= 1'b0;
      w_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      hit_count <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= SHIFT;
          w <= data[WIDTH-1];
          sr <= data << 1;
          cnt <= eff_len;
          prev <= 1'b0;
          hit_count <= '0;
          w_valid <= 1'b1;
          busy <= 1'b1;
        end
        SHIFT: begin
          hit_count <= (w && prev && hit_count != 4'hf) ? hit_count + 4'd1 : hit_count;
          prev <= w;
          cnt <= cnt - 4'd1;
          sr <= sr << 1;
          w <= last ? 1'b0 : sr[WIDTH-1];
          w_valid <= !last;
          done <= last;
          state <= last ? DONE : SHIFT;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: begin
          state <= IDLE;
          w <= 1'b0;
          w_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: table, corner-case and random frames against a bit-list reference model
module tb_serial_pattern_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] len = '0;
  logic w, w_valid, busy, done;
  logic [3:0] hit_count;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    int n;
    int hits;
  } vec_t;
  vec_t tbl[10];
  serial_pattern_tx #(.WIDTH(8)) dut (
    .Clock(clk), .Reset(rst), .start(start), .data(data), .len(len),
    .w(w), .w_valid(w_valid), .busy(busy), .done(done), .hit_count(hit_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int frame_len(input logic [3:0] l);
    return (l == 0 || l > 8) ? 8 : int'(l);
  endfunction
  function automatic int model_hits(input logic [7:0] d, input int n);
    int bits[$];
    int h = 0;
    for (int i = 0; i < n; i++) bits.push_back(int'(d[7 - i]));
    for (int i = 1; i < bits.size(); i++) h += (bits[i] == 1 && bits[i - 1] == 1) ? 1 : 0;
    return h;
  endfunction
  task automatic run_frame(input logic [7:0] d, input logic [3:0] l, input int n, input int hits);
    @(negedge clk);
    data = d;
    len = l;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      data = 8'($urandom);
      len = 4'($urandom);
      check($sformatf("w[%0d] d=%h l=%0d", i, d, l), int'(w), int'(d[7 - i]));
      check("w_valid shift", int'(w_valid), 1);
      check("busy shift", int'(busy), 1);
      check("done shift", int'(done), 0);
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    check("done pulse", int'(done), 1);
    check("w_valid done", int'(w_valid), 0);
    check("w done", int'(w), 0);
    check("busy done", int'(busy), 1);
    check($sformatf("hit_count d=%h l=%0d", d, l), int'(hit_count), hits);
    @(negedge clk);
    check("done idle", int'(done), 0);
    check("busy idle", int'(busy), 0);
    check("hit_count held", int'(hit_count), hits);
  endtask
  initial begin
    tbl[0] = '{8'b1011_0111, 4'd8, 8, 3};
    tbl[1] = '{8'hE0, 4'd3, 3, 2};
    tbl[2] = '{8'hFF, 4'd0, 8, 7};
    tbl[3] = '{8'hFF, 4'd12, 8, 7};
    tbl[4] = '{8'hFF, 4'd1, 1, 0};
    tbl[5] = '{8'hAA, 4'd8, 8, 0};
    tbl[6] = '{8'hC3, 4'd15, 8, 2};
    tbl[7] = '{8'h01, 4'd8, 8, 0};
    tbl[8] = '{8'h80, 4'd2, 2, 0};
    tbl[9] = '{8'h7E, 4'd7, 7, 5};
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("reset w", int'(w), 0);
    check("reset w_valid", int'(w_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset hit_count", int'(hit_count), 0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle after reset busy", int'(busy), 0);
    for (int k = 0; k < 10; k++) run_frame(tbl[k].data, tbl[k].len, tbl[k].n, tbl[k].hits);
    run_frame(8'hFF, 4'd8, 8, 7);
    @(negedge clk);
    data = 8'hFF;
    len = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("abort pre busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort w_valid", int'(w_valid), 0);
    check("abort hit_count", int'(hit_count), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort no done", int'(done), 0);
      check("abort stays idle", int'(busy), 0);
    end
    data = 8'hC0;
    len = 4'd2;
    start = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("cont f%0d c%0d w_valid", f, c), int'(w_valid), c < 2 ? 1 : 0);
        check($sformatf("cont f%0d c%0d done", f, c), int'(done), c == 2 ? 1 : 0);
        check($sformatf("cont f%0d c%0d busy", f, c), int'(busy), c < 3 ? 1 : 0);
        if (c < 2) check("cont w", int'(w), 1);
        if (c == 2) check("cont hit_count", int'(hit_count), 1);
      end
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic [3:0] l;
      d = 8'($urandom);
      l = 4'($urandom_range(0, 15));
      run_frame(d, l, frame_len(l), model_hits(d, frame_len(l)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
